// File: rtl/car_frame_parser.sv
// Assembles 5-byte car records (header, id, x, y, xor checksum) from a UART byte stream.
// Publishes id/x/y on a valid strobe; discards bad or stalled frames with an error strobe.
module car_frame_parser #(
    parameter int unsigned          width     = 8,
    parameter logic [width-1:0]     header    = 8'hAA,
    parameter int unsigned          timeout   = 104160,
    parameter int unsigned          cnt_width = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] i_rx_data,
    input  logic             i_rx_done,
    output logic [width-1:0] o_id,
    output logic [width-1:0] o_x,
    output logic [width-1:0] o_y,
    output logic             o_valid,
    output logic             o_err,
    output logic [7:0]       o_frame_cnt,
    output logic [7:0]       o_err_cnt
);

    localparam int unsigned stat_width = 8;
    // Counter value whose increment would reach timeout-1: expiry fires on that edge.
    localparam logic [cnt_width-1:0] expire_val = cnt_width'(timeout - 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_ID  = 3'd1,
        GET_X   = 3'd2,
        GET_Y   = 3'd3,
        GET_CHK = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic [width-1:0]     id_s, x_s, y_s;
    logic                 valid_d, err_d;

    // Next-state, inter-byte timeout and frame verdict
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (state_q != IDLE && !i_rx_done) begin
            if (cnt_q == expire_val) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + cnt_width'(1);
            end
        end

        if (i_rx_done) begin
            case (state_q)
                IDLE:    if (i_rx_data == header) state_d = GET_ID;
                GET_ID:  state_d = GET_X;
                GET_X:   state_d = GET_Y;
                GET_Y:   state_d = GET_CHK;
                GET_CHK: begin
                    if (i_rx_data == (id_s ^ x_s ^ y_s)) valid_d = 1'b1;
                    else                                 err_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shadow capture of in-flight fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_s <= '0;
            x_s  <= '0;
            y_s  <= '0;
        end else if (i_rx_done) begin
            if (state_q == GET_ID) id_s <= i_rx_data;
            if (state_q == GET_X)  x_s  <= i_rx_data;
            if (state_q == GET_Y)  y_s  <= i_rx_data;
        end
    end

    // Published record, strobes and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_id        <= '0;
            o_x         <= '0;
            o_y         <= '0;
            o_valid     <= 1'b0;
            o_err       <= 1'b0;
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
        end else begin
            o_valid <= valid_d;
            o_err   <= err_d;
            if (valid_d) begin
                o_id        <= id_s;
                o_x         <= x_s;
                o_y         <= y_s;
                o_frame_cnt <= o_frame_cnt + stat_width'(1);
            end
            if (err_d && o_err_cnt != {stat_width{1'b1}}) begin
                o_err_cnt <= o_err_cnt + stat_width'(1);
            end
        end
    end

endmodule

// File: tb/tb_car_frame_parser.sv
// Randomized scoreboard bench for car_frame_parser with a frame-level reference model.
module tb_car_frame_parser;

    localparam int unsigned TIMEOUT = 200;
    localparam int unsigned CNT_W   = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] o_id, o_x, o_y, o_frame_cnt, o_err_cnt;
    logic       o_valid, o_err;

    car_frame_parser #(
        .width(8), .header(8'hAA), .timeout(TIMEOUT), .cnt_width(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_id(o_id), .o_x(o_x), .o_y(o_y), .o_valid(o_valid), .o_err(o_err),
        .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        int         cyc;
        logic [7:0] id, x, y, fc, ec;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: frame in progress as a byte list
    bit         in_frame;
    int         last_edge;
    logic [7:0] fr[$];
    logic [7:0] m_id, m_x, m_y, m_fc, m_ec;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic push_event(input bit is_err, input int edge_n);
        exp_t e;
        e.is_err = is_err; e.cyc = edge_n;
        e.id = m_id; e.x = m_x; e.y = m_y; e.fc = m_fc; e.ec = m_ec;
        expq.push_back(e);
    endtask

    task automatic model_reset();
        in_frame = 0; fr.delete(); last_edge = 0;
        m_id = 0; m_x = 0; m_y = 0; m_fc = 0; m_ec = 0;
    endtask

    task automatic model_err(input int edge_n);
        if (m_ec != 8'd255) m_ec = m_ec + 8'd1;
        push_event(1'b1, edge_n);
    endtask

    task automatic model_byte(input int edge_n, input logic [7:0] b);
        if (!in_frame) begin
            if (b == 8'hAA) begin
                in_frame = 1; fr.delete(); last_edge = edge_n;
            end
        end else begin
            fr.push_back(b);
            last_edge = edge_n;
            if (fr.size() == 4) begin
                in_frame = 0;
                if ((fr[0] ^ fr[1] ^ fr[2]) == fr[3]) begin
                    m_id = fr[0]; m_x = fr[1]; m_y = fr[2];
                    m_fc = m_fc + 8'd1;
                    push_event(1'b0, edge_n);
                end else begin
                    model_err(edge_n);
                end
            end
        end
    endtask

    // Called at #1 after an edge; the byte is sampled on the next edge.
    task automatic send(input logic [7:0] b);
        model_byte(cyc + 1, b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    // n idle edges; a frame left waiting expires timeout-1 edges after its last byte.
    task automatic gap(input int n);
        int e;
        if (in_frame && n > 0) begin
            e = last_edge + int'(TIMEOUT) - 1;
            if (e >= cyc + 1 && e <= cyc + n) begin
                in_frame = 0;
                model_err(e);
            end
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] chk, input int glo, input int ghi);
        send(8'hAA); gap(int'($urandom_range(ghi, glo)));
        send(id);    gap(int'($urandom_range(ghi, glo)));
        send(x);     gap(int'($urandom_range(ghi, glo)));
        send(y);     gap(int'($urandom_range(ghi, glo)));
        send(chk);   gap(int'($urandom_range(ghi, glo)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_id"}, o_id, 0);
        check({tag, "_x"}, o_x, 0);
        check({tag, "_y"}, o_y, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_err"}, o_err, 0);
        check({tag, "_fcnt"}, o_frame_cnt, 0);
        check({tag, "_ecnt"}, o_err_cnt, 0);
    endtask

    task automatic do_reset();
        rx_done = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all_zero("async_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (o_valid || o_err)) begin
            checks++;
            if (o_valid && o_err) begin
                errors++;
                $display("FAIL strobe_overlap: valid and err both high at cycle %0d", cyc);
            end else if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b at cycle %0d, none expected",
                         o_valid, o_err, cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (e.is_err != o_err || e.cyc != cyc || e.id != o_id || e.x != o_x ||
                    e.y != o_y || e.fc != o_frame_cnt || e.ec != o_err_cnt) begin
                    errors++;
                    $display("FAIL frame_event: got err=%0b cyc=%0d id=%h x=%h y=%h fc=%0d ec=%0d want err=%0b cyc=%0d id=%h x=%h y=%h fc=%0d ec=%0d",
                             o_err, cyc, o_id, o_x, o_y, o_frame_cnt, o_err_cnt,
                             e.is_err, e.cyc, e.id, e.x, e.y, e.fc, e.ec);
                end
            end
        end
    end

    initial begin
        logic [7:0] a, b, c;
        int r;
        rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        gap(2);

        // Good frame, 100 cycles between bytes
        send_frame(8'h03, 8'h10, 8'h20, 8'h33, 99, 99);
        check("good_id", o_id, 8'h03);
        check("good_fcnt", o_frame_cnt, 1);

        // Bad checksum keeps previous record
        send_frame(8'h05, 8'h07, 8'h09, 8'h00, 5, 20);
        check("bad_hold_x", o_x, 8'h10);
        check("bad_ecnt", o_err_cnt, 1);

        // Timeout after a stalled frame
        send(8'hAA); gap(3); send(8'h01); gap(int'(TIMEOUT) + 20);
        check("timeout_ecnt", o_err_cnt, 2);

        // Byte arriving exactly on the expiry edge is accepted
        send(8'hAA); gap(3); send(8'h01); gap(int'(TIMEOUT) - 2);
        send(8'h02); gap(4); send(8'h03); gap(4); send(8'h00); gap(4);
        check("boundary_fcnt", o_frame_cnt, 2);
        check("boundary_ecnt", o_err_cnt, 2);

        // Idle noise, then header bytes used as data
        send(8'h55); gap(3); send(8'h00); gap(3);
        send_frame(8'hAA, 8'hAA, 8'hAA, 8'hAA, 2, 6);
        check("hdr_data_y", o_y, 8'hAA);

        // Reset in the middle of a frame, trailing bytes ignored
        send(8'hAA); gap(3); send(8'h07); gap(3); send(8'h08); gap(3);
        do_reset();
        gap(2);
        send(8'h09); gap(3); send(8'h5C); gap(3);
        send_frame(8'h11, 8'h22, 8'h44, 8'h77, 2, 6);
        check("post_reset_id", o_id, 8'h11);
        check("post_reset_fcnt", o_frame_cnt, 1);

        // 300 back-to-back good frames wrap the frame counter
        do_reset();
        gap(2);
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            send_frame(a, b, c, a ^ b ^ c, 1, 5);
        end
        check("wrap_fcnt", o_frame_cnt, 44);

        // 260 bad frames saturate the error counter
        for (int i = 0; i < 260; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            send_frame(a, b, c, a ^ b ^ c ^ 8'($urandom_range(255, 1)), 1, 4);
        end
        check("sat_ecnt", o_err_cnt, 255);
        check("sat_fcnt", o_frame_cnt, 44);

        // Mixed random traffic, including gaps straddling the expiry edge
        do_reset();
        gap(2);
        for (int i = 0; i < 120; i++) begin
            r = int'($urandom_range(9, 0));
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            if (r <= 1) begin
                send(8'($urandom)); gap(int'($urandom_range(6, 1)));
            end else if (r <= 5) begin
                send_frame(a, b, c, a ^ b ^ c, 1, 8);
            end else if (r <= 7) begin
                send_frame(a, b, c, 8'($urandom), 1, 8);
            end else if (r == 8) begin
                send(8'hAA); gap(2); send(a); gap(int'($urandom_range(TIMEOUT + 10, TIMEOUT - 3)));
            end else begin
                send(8'hAA); gap(2); send(a);
                gap(int'($urandom_range(TIMEOUT - 1, TIMEOUT - 3)));
                send(b); gap(2); send(c); gap(2); send(a ^ b ^ c); gap(2);
            end
        end
        gap(int'(TIMEOUT) + 5);
        check("final_fcnt", o_frame_cnt, m_fc);
        check("final_ecnt", o_err_cnt, m_ec);
        check("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/car_frame_parser.md
# car_frame_parser

Byte-stream frame parser between the UART receiver and the speed calculation stage. It consumes the byte-plus-done-pulse output of the 19200-baud receiver and assembles fixed 5-byte car records: header, id, x, y, checksum. It validates each record and presents id/x/y with a one-cycle valid strobe to the speed stage. Bad or stalled frames are discarded and reported on an error strobe and an error counter.

## Interface
- width, 8, data byte / field width (id, x, y)
- header, 8'hAA, start-of-frame byte value
- timeout, 104160, max idle cycles between bytes inside a frame (4 byte times at 50 MHz / 19200)
- cnt_width, 17, width of the inter-byte timeout counter (must hold timeout-1)

- clk  input  1  system clock, 50 MHz; one clock domain only
- rst_n  input  1  asynchronous active-low reset
- i_rx_data  input  width  received byte, valid when i_rx_done=1
- i_rx_done  input  1  one-cycle strobe from UART receiver
- o_id  output  width  car id of last valid frame
- o_x  output  width  x location of last valid frame
- o_y  output  width  y location of last valid frame
- o_valid  output  1  one-cycle strobe: o_id/o_x/o_y updated with a new frame
- o_err  output  1  one-cycle strobe: frame discarded (checksum or timeout)
- o_frame_cnt  output  8  count of valid frames, wraps 255->0
- o_err_cnt  output  8  count of discarded frames, saturates at 255

## Operation
- FSM states: IDLE, GET_ID, GET_X, GET_Y, GET_CHK. All transitions occur only on clock edges with i_rx_done=1, except timeout.
- IDLE: byte == header -> GET_ID; any other byte ignored, with no error. The timeout counter is inactive in IDLE.
- GET_ID / GET_X / GET_Y: latch the byte into shadow registers id_s / x_s / y_s, then advance. A byte equal to header inside a frame is plain data; there is no mid-frame resync.
- GET_CHK: the expected checksum is id_s ^ x_s ^ y_s.
  - Match: copy shadows to o_id/o_x/o_y, pulse o_valid, increment o_frame_cnt, go to IDLE.
  - Mismatch: outputs unchanged, pulse o_err, increment o_err_cnt (saturating), go to IDLE.
- Timeout:
  - In any state except IDLE, the counter clears on every i_rx_done and on entry to GET_ID, and increments otherwise.
  - When the counter equals timeout-1 and i_rx_done=0: pulse o_err, increment o_err_cnt, go to IDLE, clear the counter.
- Simultaneous events: if i_rx_done=1 in the same cycle the counter reaches timeout-1, the byte is processed normally and no timeout occurs.
- o_valid and o_err are never asserted in the same cycle.
- o_id/o_x/o_y hold their value between valid frames. Shadow registers never reach the outputs on a bad frame.
- Input assumption: i_rx_done is never high in consecutive cycles. The block does not depend on this for correctness; each high cycle is one byte.

## Timing
- Reset (async assert, sync use after deassert):
  - state = IDLE, counter = 0
  - o_id = o_x = o_y = 0, o_valid = o_err = 0
  - o_frame_cnt = o_err_cnt = 0
  - shadows = 0
- Latency: i_rx_done for the checksum byte sampled at edge N -> o_valid (or o_err) high during cycle N+1 through edge N+1, for exactly one cycle. o_id/o_x/o_y are updated at edge N, together with o_valid rising.
- Timeout: last byte accepted at edge N -> o_err high after edge N+timeout-1, assuming no further i_rx_done.
- Reset mid-frame: partial frame discarded silently. There is no o_err pulse and the counters are cleared.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Good frame: bytes AA,03,10,20,33 (0x03^0x10^0x20=0x33), one cycle strobe each, 100 cycles apart -> one o_valid pulse the cycle after the 0x33 strobe; o_id=03, o_x=10, o_y=20, o_frame_cnt=1, o_err never high.
- Bad checksum: AA,05,07,09,00 (expected 0x0B) -> one o_err pulse, o_err_cnt=1, outputs keep the previous frame's 03/10/20, o_valid never high.
- Timeout and boundary: AA,01, then silence -> o_err exactly timeout-1 cycles after the 0x01 strobe. Repeat with a byte arriving on the exact expiry cycle -> no error, FSM advances.
- Idle noise and in-frame header: 55,00,AA,AA,AA,AA,AA (checksum AA^AA^AA=AA) -> the first two bytes are ignored; one o_valid with o_id=o_x=o_y=AA.
- Back-to-back frames at full baud rate (bytes every 26040 cycles), 300 good frames -> 300 o_valid pulses, o_frame_cnt wraps to 44. Then 260 bad frames -> o_err_cnt saturates at 255.
- Reset mid-frame: assert rst_n low asynchronously after AA,07,08 -> all outputs 0 immediately. After release, the bytes 09,xx are ignored in IDLE; a following good frame parses correctly.
